// File: rtl/bonus_score_tracker.sv
// Per-game score FSM: level-based start score, one-shot +5/-5 boxes, exit freeze.
// Optional per-second decay is built only when SCORE_DECAY_EN is defined.
module bonus_score_tracker #(
  parameter int TICK_CYCLES = 50000000,
  parameter int BASE_EASY   = 100,
  parameter int BASE_MED    = 200,
  parameter int BASE_HARD   = 300,
  parameter int SCORE_MAX   = 999
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       playHard,
  input  logic       playMedium,
  input  logic       playEasy,
  input  logic       externalReset,
  input  logic [4:0] scorePlusFiveX,
  input  logic [4:0] scorePlusFiveY,
  input  logic [4:0] scoreMinusFiveX,
  input  logic [4:0] scoreMinusFiveY,
  input  logic [4:0] playerX,
  input  logic [4:0] playerY,
  input  logic       moveValid,
  input  logic       reachedExit,
  output logic [9:0] score,
  output logic       plusTaken,
  output logic       minusTaken,
  output logic       playing,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;

  localparam logic signed [11:0] SMAX = 12'(SCORE_MAX);

  state_t            state, state_nxt;
  logic [9:0]        score_nxt, base;
  logic              plus_nxt, minus_nxt;
  logic              one_hot, abort, plus_hit, minus_hit, tick;
  logic signed [11:0] delta, sum;
  logic [9:0]        sat;

  assign one_hot = ($countones({playHard, playMedium, playEasy}) == 1);
  assign abort   = externalReset || !(playHard || playMedium || playEasy);

  assign plus_hit  = (state == PLAYING) && moveValid && !plusTaken &&
                     (playerX == scorePlusFiveX) && (playerY == scorePlusFiveY);
  assign minus_hit = (state == PLAYING) && moveValid && !minusTaken &&
                     (playerX == scoreMinusFiveX) && (playerY == scoreMinusFiveY);

`ifdef SCORE_DECAY_EN
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  logic [CW-1:0] tick_cnt;

  assign tick = (state == PLAYING) && (tick_cnt == CW'(TICK_CYCLES - 1));

  // Held at zero outside PLAYING so every game starts a full second from entry.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                        tick_cnt <= '0;
    else if (state != PLAYING || tick)  tick_cnt <= '0;
    else                                tick_cnt <= tick_cnt + 1'b1;
  end
`else
  assign tick = 1'b0;
`endif

  always_comb begin
    base = 10'(BASE_EASY);
    if (playHard)        base = 10'(BASE_HARD);
    else if (playMedium) base = 10'(BASE_MED);
  end

  // One net delta per cycle, saturated into [0, SCORE_MAX].
  always_comb begin
    delta = '0;
    if (plus_hit)  delta = delta + 12'sd5;
    if (minus_hit) delta = delta - 12'sd5;
    if (tick)      delta = delta - 12'sd1;
    sum = $signed({2'b00, score}) + delta;
    if (sum < 12'sd0)     sat = '0;
    else if (sum > SMAX)  sat = SMAX[9:0];
    else                  sat = sum[9:0];
  end

  always_comb begin
    state_nxt = state;
    score_nxt = score;
    plus_nxt  = plusTaken;
    minus_nxt = minusTaken;
    case (state)
      IDLE: begin
        score_nxt = '0;
        plus_nxt  = 1'b0;
        minus_nxt = 1'b0;
        if (one_hot && !externalReset) begin
          state_nxt = PLAYING;
          score_nxt = base;
        end
      end
      PLAYING: begin
        if (abort) begin
          state_nxt = IDLE;
          score_nxt = '0;
          plus_nxt  = 1'b0;
          minus_nxt = 1'b0;
        end else begin
          score_nxt = sat;
          plus_nxt  = plusTaken | plus_hit;
          minus_nxt = minusTaken | minus_hit;
          if (reachedExit) state_nxt = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
          score_nxt = '0;
          plus_nxt  = 1'b0;
          minus_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        score_nxt = '0;
        plus_nxt  = 1'b0;
        minus_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      score      <= '0;
      plusTaken  <= 1'b0;
      minusTaken <= 1'b0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      score      <= score_nxt;
      plusTaken  <= plus_nxt;
      minusTaken <= minus_nxt;
      playing    <= (state_nxt == PLAYING);
      done       <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_bonus_score_tracker.sv
// Directed bench for bonus_score_tracker; expectations adapt to SCORE_DECAY_EN.
module tb_bonus_score_tracker;
  localparam int TC = 10;
`ifdef SCORE_DECAY_EN
  localparam bit DECAY = 1'b1;
`else
  localparam bit DECAY = 1'b0;
`endif

  logic       clock, resetn;
  logic       playHard, playMedium, playEasy, externalReset;
  logic [4:0] scorePlusFiveX, scorePlusFiveY, scoreMinusFiveX, scoreMinusFiveY;
  logic [4:0] playerX, playerY;
  logic       moveValid, reachedExit;
  logic [9:0] score;
  logic       plusTaken, minusTaken, playing, done;

  int checks = 0;
  int failures = 0;

  bonus_score_tracker #(.TICK_CYCLES(TC)) dut (
    .clock(clock), .resetn(resetn),
    .playHard(playHard), .playMedium(playMedium), .playEasy(playEasy),
    .externalReset(externalReset),
    .scorePlusFiveX(scorePlusFiveX), .scorePlusFiveY(scorePlusFiveY),
    .scoreMinusFiveX(scoreMinusFiveX), .scoreMinusFiveY(scoreMinusFiveY),
    .playerX(playerX), .playerY(playerY),
    .moveValid(moveValid), .reachedExit(reachedExit),
    .score(score), .plusTaken(plusTaken), .minusTaken(minusTaken),
    .playing(playing), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic move(input logic [4:0] x, input logic [4:0] y);
    playerX = x; playerY = y; moveValid = 1'b1;
    step();
    moveValid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; playHard = 0; playMedium = 0; playEasy = 0; externalReset = 0;
    scorePlusFiveX = 5'd17; scorePlusFiveY = 5'd9;
    scoreMinusFiveX = 5'd15; scoreMinusFiveY = 5'd19;
    playerX = 0; playerY = 0; moveValid = 0; reachedExit = 0;
    #12 resetn = 1'b1;
    check("rst_score", 32'(score), 0);
    check("rst_flags", 32'({plusTaken, minusTaken, playing, done}), 0);

    // Easy: start score and decay schedule
    playEasy = 1'b1; step();
    check("easy_entry", 32'(score), 100);
    check("easy_playing", 32'(playing), 1);
    step(10);
    check("easy_10", 32'(score), DECAY ? 99 : 100);
    step(40);
    check("easy_50", 32'(score), DECAY ? 95 : 100);
    playEasy = 1'b0; step();
    check("easy_exit_idle", 32'({playing, score}), 0);

    // Medium: plus box taken once only
    playMedium = 1'b1; step();
    check("med_entry", 32'(score), 200);
    move(17, 9);
    check("plus_first", 32'(score), 205);
    check("plus_flag", 32'(plusTaken), 1);
    move(17, 9);
    check("plus_second", 32'(score), 205);
    playMedium = 1'b0; step();

    // Hard: decay down to 2, then minus box saturates at 0
    playHard = 1'b1; step();
    check("hard_entry", 32'(score), 300);
    step(2980);
    check("hard_decayed", 32'(score), DECAY ? 2 : 300);
    move(15, 19);
    check("minus_sat", 32'(score), DECAY ? 0 : 295);
    check("minus_flag", 32'(minusTaken), 1);
    playHard = 1'b0; step();

    // Tick + plus box + exit in the same cycle, then frozen
    playMedium = 1'b1; step();
    step(500);
    check("med_150", 32'(score), DECAY ? 150 : 200);
    step(9);
    playerX = 17; playerY = 9; moveValid = 1'b1; reachedExit = 1'b1;
    step();
    moveValid = 1'b0; reachedExit = 1'b0;
    check("combo_score", 32'(score), DECAY ? 154 : 205);
    check("combo_done", 32'({done, playing}), 32'b10);
    move(15, 19);
    step(100);
    check("frozen_score", 32'(score), DECAY ? 154 : 205);
    check("frozen_minus", 32'(minusTaken), 0);
    check("frozen_done", 32'(done), 1);
    externalReset = 1'b1; playMedium = 1'b0; step();
    externalReset = 1'b0;
    check("done_abort", 32'({done, plusTaken, score}), 0);

    // externalReset mid-game, re-entry, then async reset
    playMedium = 1'b1; step();
    move(17, 9);
    step(199);
    check("mid_score", 32'(score), DECAY ? 185 : 205);
    externalReset = 1'b1; step();
    check("xr_state", 32'({playing, done}), 0);
    check("xr_score", 32'(score), 0);
    check("xr_plus", 32'(plusTaken), 0);
    externalReset = 1'b0; step();
    check("reentry", 32'({playing, score}), 32'({1'b1, 10'd200}));
    #2 resetn = 1'b0;
    #1;
    check("async_rst", 32'({score, plusTaken, minusTaken, playing, done}), 0);
    playMedium = 1'b0; step();
    resetn = 1'b1; step();

    // Illegal multi-hot selection stays in IDLE
    playHard = 1'b1; playEasy = 1'b1; step(3);
    check("multihot", 32'({playing, score}), 0);
    playHard = 1'b0; playEasy = 1'b0; step();

    // Both boxes on one cell: both consumed, net zero
    scoreMinusFiveX = 5'd17; scoreMinusFiveY = 5'd9;
    playEasy = 1'b1; step();
    move(17, 9);
    check("same_cell_score", 32'(score), 100);
    check("same_cell_flags", 32'({plusTaken, minusTaken}), 32'b11);
    playEasy = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
